// File: rtl/regs_wb_queue_if.sv
// Write-back queue bus: request side from the datapath and the register-file
// write port. The queue itself uses the slave modport.
interface regs_wb_queue_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_wnum;
    logic [DW-1:0] in_wdata;
    logic          we;
    logic [AW-1:0] wnum;
    logic [DW-1:0] wdata;

    modport master (
        output in_valid, in_wnum, in_wdata,
        input  in_ready, we, wnum, wdata
    );

    modport slave (
        input  in_valid, in_wnum, in_wdata,
        output in_ready, we, wnum, wdata
    );
endinterface

// File: rtl/regs_wb_queue.sv
// Write-back queue for the 16x32 register file write port.
// Buffers datapath write requests and drains one per cycle, holding off
// whenever the datapath performs a register read (rd_req) or a flush.
// Optional lookup port, enabled by defining REGS_WBQ_BYPASS_EN, returns the
// youngest pending value for lk_num; without it lk_hit/lk_data are tied to 0.
module regs_wb_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    regs_wb_queue_if.slave           bus,
    input  logic                     rd_req,
    input  logic                     flush,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    input  logic [AW-1:0]            lk_num,
    output logic                     lk_hit,
    output logic [DW-1:0]            lk_data
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [AW-1:0] mem_wnum  [DEPTH];
    logic [DW-1:0] mem_wdata [DEPTH];

    logic full;
    logic accept;
    logic store_ok;
    logic push;
    logic pop;

    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);
    assign bus.in_ready = ~full;
    assign accept       = bus.in_valid & bus.in_ready;

    // r0 and numbers beyond the 16-entry file are swallowed, never stored
    assign store_ok = (bus.in_wnum != '0) &&
                      ({{(32-AW){1'b0}}, bus.in_wnum} < 32'd16);
    assign push     = accept & store_ok & ~flush;
    assign pop      = bus.we;

    // Drain from head; a read cycle or flush leaves the write port idle
    always_comb begin
        bus.we    = ~empty & ~rd_req & ~flush;
        bus.wnum  = '0;
        bus.wdata = '0;
        if (bus.we) begin
            bus.wnum  = mem_wnum[rd_ptr];
            bus.wdata = mem_wdata[rd_ptr];
        end
    end

    // Pointers and occupancy; flush wins over any push/pop at the same edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage written at the tail
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_wnum[i]  <= '0;
                mem_wdata[i] <= '0;
            end
        end else if (push) begin
            mem_wnum[wr_ptr]  <= bus.in_wnum;
            mem_wdata[wr_ptr] <= bus.in_wdata;
        end
    end

`ifdef REGS_WBQ_BYPASS_EN
    // Scan oldest to youngest so the last match is the youngest pending value
    always_comb begin
        lk_hit  = 1'b0;
        lk_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((CW'(k) < count) && (lk_num != '0) &&
                (mem_wnum[rd_ptr + PW'(k)] == lk_num)) begin
                lk_hit  = 1'b1;
                lk_data = mem_wdata[rd_ptr + PW'(k)];
            end
        end
    end
`else
    logic unused_lk_num;
    assign unused_lk_num = ^lk_num;
    assign lk_hit        = 1'b0;
    assign lk_data       = '0;
`endif

endmodule

// File: tb/tb_regs_wb_queue.sv
// Self-checking bench for regs_wb_queue: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_regs_wb_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;

    typedef struct {
        logic [AW-1:0] n;
        logic [DW-1:0] d;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rd_req = 1'b0;
    logic flush = 1'b0;
    logic empty;
    logic [$clog2(DEPTH):0] count;
    logic [AW-1:0] lk_num = '0;
    logic lk_hit;
    logic [DW-1:0] lk_data;

    regs_wb_queue_if #(.AW(AW), .DW(DW)) bus ();

    regs_wb_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.slave),
        .rd_req  (rd_req),
        .flush   (flush),
        .empty   (empty),
        .count   (count),
        .lk_num  (lk_num),
        .lk_hit  (lk_hit),
        .lk_data (lk_data)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    ent_t q[$];

    logic          obs_we, obs_empty, obs_ready, obs_hit;
    logic [AW-1:0] obs_wnum;
    logic [DW-1:0] obs_wdata, obs_ldata;
    int            obs_count;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check against the model, then
    // advance the model with what the queue should have done at the edge.
    task automatic step(input logic v, input logic [AW-1:0] n, input logic [DW-1:0] d,
                        input logic rr, input logic fl, input logic [AW-1:0] lk);
        logic          e_ready, e_we, e_hit;
        logic [AW-1:0] e_wnum;
        logic [DW-1:0] e_wdata, e_ldata;
        @(negedge clk);
        bus.in_valid = v;
        bus.in_wnum  = n;
        bus.in_wdata = d;
        rd_req       = rr;
        flush        = fl;
        lk_num       = lk;
        #1;
        e_ready = (q.size() < DEPTH);
        e_we    = (q.size() > 0) && !rr && !fl;
        e_wnum  = e_we ? q[0].n : '0;
        e_wdata = e_we ? q[0].d : '0;
        e_hit   = 1'b0;
        e_ldata = '0;
`ifdef REGS_WBQ_BYPASS_EN
        if (lk != 0)
            foreach (q[i])
                if (q[i].n == lk) begin
                    e_hit   = 1'b1;
                    e_ldata = q[i].d;
                end
`endif
        obs_we = bus.we; obs_wnum = bus.wnum; obs_wdata = bus.wdata;
        obs_empty = empty; obs_ready = bus.in_ready; obs_count = int'(count);
        obs_hit = lk_hit; obs_ldata = lk_data;
        chk("in_ready", obs_ready, e_ready);
        chk("empty", obs_empty, q.size() == 0);
        chk("count", obs_count, q.size());
        chk("we", obs_we, e_we);
        chk("wnum", obs_wnum, e_wnum);
        chk("wdata", obs_wdata, e_wdata);
        chk("lk_hit", obs_hit, e_hit);
        chk("lk_data", obs_ldata, e_ldata);
        @(posedge clk);
        if (fl) q.delete();
        else begin
            if (e_we) void'(q.pop_front());
            if (v && e_ready && n != 0 && n < 16) q.push_back('{n: n, d: d});
        end
    endtask

    task automatic idle(input logic rr);
        step(1'b0, '0, '0, rr, 1'b0, '0);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_wnum  = '0;
        bus.in_wdata = '0;
        #2;
        chk("rst_we", bus.we, 1'b0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_ready", bus.in_ready, 1'b1);
        chk("rst_count", count, 0);
        chk("rst_lk_hit", lk_hit, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // single write latency
        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, '0);
        idle(1'b0);
        chk("t2_we", obs_we, 1'b1);
        chk("t2_wnum", obs_wnum, 5'd5);
        chk("t2_wdata", obs_wdata, 32'hDEADBEEF);
        idle(1'b0);
        chk("t2_empty", obs_empty, 1'b1);

        // stall to full, then drain in order
        for (int i = 1; i <= 4; i++) step(1'b1, AW'(i), DW'(i * 16), 1'b1, 1'b0, '0);
        step(1'b1, 5'd9, 32'h99, 1'b1, 1'b0, '0);
        chk("t3_ready", obs_ready, 1'b0);
        chk("t3_we", obs_we, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            idle(1'b0);
            chk("t3_drain_we", obs_we, 1'b1);
            chk("t3_drain_wnum", obs_wnum, AW'(i));
        end

        // simultaneous push/pop with pointer wrap
        step(1'b1, 5'd10, 32'hA0, 1'b1, 1'b0, '0);
        step(1'b1, 5'd11, 32'hA1, 1'b1, 1'b0, '0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, AW'(1 + i), DW'(32'hB0 + i), 1'b0, 1'b0, '0);
            chk("t4_count", obs_count, 2);
        end
        idle(1'b0);
        idle(1'b0);

        // r0 dropped, flush overrides push
        step(1'b1, 5'd0, 32'h1234, 1'b0, 1'b0, '0);
        idle(1'b0);
        chk("t5_r0_count", obs_count, 0);
        chk("t5_r0_we", obs_we, 1'b0);
        step(1'b1, 5'd6, 32'h66, 1'b1, 1'b0, '0);
        step(1'b1, 5'd7, 32'h77, 1'b0, 1'b1, '0);
        chk("t5_flush_we", obs_we, 1'b0);
        idle(1'b0);
        chk("t5_flush_count", obs_count, 0);
        chk("t5_flush_we2", obs_we, 1'b0);

        // lookup returns youngest pending value
        step(1'b1, 5'd3, 32'd1, 1'b1, 1'b0, '0);
        step(1'b1, 5'd3, 32'd2, 1'b1, 1'b0, '0);
        step(1'b0, '0, '0, 1'b1, 1'b0, 5'd3);
`ifdef REGS_WBQ_BYPASS_EN
        chk("t6_hit", obs_hit, 1'b1);
        chk("t6_data", obs_ldata, 32'd2);
`else
        chk("t6_hit_off", obs_hit, 1'b0);
        chk("t6_data_off", obs_ldata, 32'd0);
`endif
        idle(1'b0);
        idle(1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0, 5'd3);
        chk("t6_hit_after", obs_hit, 1'b0);

        // reset mid-drain
        for (int i = 0; i < 3; i++) step(1'b1, AW'(12 + i), DW'(i), 1'b1, 1'b0, '0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rd_req = 1'b0;
        #1;
        chk("t1_pre_we", bus.we, 1'b1);
        rst = 1'b0;
        #1;
        chk("t1_we", bus.we, 1'b0);
        chk("t1_empty", empty, 1'b1);
        chk("t1_ready", bus.in_ready, 1'b1);
        q.delete();
        @(negedge clk);
        rst = 1'b1;
        idle(1'b0);
        chk("t1_count", obs_count, 0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [AW-1:0] lk;
            lk = AW'($urandom_range(0, 15));
            if (q.size() > 0 && $urandom_range(0, 1) == 1)
                lk = q[$urandom_range(0, q.size() - 1)].n;
            step($urandom_range(0, 9) < 7, AW'($urandom_range(0, 19)), $urandom,
                 $urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0, lk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
